// File: rtl/router_pkg.sv
// Shared types and helpers for the router ingress arbiter: FSM states,
// header layout and widths.
package router_pkg;

    localparam int unsigned LEN_W  = 6;
    localparam int unsigned DATA_W = 8;
    localparam logic [1:0]  ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PLD,
        PAR,
        DROP,
        GAP
    } state_t;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [1:0]       addr;
    } hdr_t;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] b);
        hdr_t h;
        h = hdr_t'(b);
        return h.len;
    endfunction

    function automatic logic [1:0] hdr_addr(input logic [DATA_W-1:0] b);
        hdr_t h;
        h = hdr_t'(b);
        return h.addr;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester strictly after ptr,
// wrapping cyclically; ptr itself is checked last.
module rr_pick #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_SRC-1:0] onehot_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             found_c
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot_c = '0;
        idx_c    = '0;
        found_c  = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N_SRC);
            if (!found_c && req[cand]) begin
                found_c        = 1'b1;
                idx_c          = cand;
                onehot_c[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_ingress_arb.sv
// Ingress arbiter and framer: shares the router input among N_SRC packet
// sources, frames packets, drops addr 3, flags truncation and parity errors.
module router_ingress_arb
    import router_pkg::*;
#(
    parameter int unsigned N_SRC = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic [N_SRC-1:0]        src_ready,
    output logic [N_SRC-1:0]        gnt,
    input  logic                    busy,
    output logic [DATA_W-1:0]       data_in,
    output logic                    pkt_valid,
    output logic                    err_addr,
    output logic                    err_trunc,
    output logic                    err_par
);

    localparam int unsigned IDX_W = $clog2(N_SRC);

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   gnt_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  par_q, par_d;
    logic [DATA_W-1:0]  data_d;
    logic               pkt_valid_d;
    logic               err_addr_d, err_trunc_d, err_par_d;

    logic [N_SRC-1:0]   pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

    logic [DATA_W-1:0]  lane [N_SRC];
    logic               cur_valid;
    logic [DATA_W-1:0]  cur_byte;
    logic               ready_en;
    logic               xfer;
    logic               trunc_ok;
    logic               trunc;

    rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (src_valid),
        .ptr      (rr_ptr_q),
        .onehot_c (pick_onehot),
        .idx_c    (pick_idx),
        .found_c  (pick_found)
    );

    for (genvar i = 0; i < N_SRC; i++) begin : g_lane
        assign lane[i] = src_data[i*DATA_W +: DATA_W];
    end

    // Byte lane and valid of the current owner (gnt is one-hot or zero)
    always_comb begin
        cur_valid = |(src_valid & gnt);
        cur_byte  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (gnt[i]) begin
                cur_byte = lane[i];
            end
        end
    end

    // DROP ignores busy since nothing is forwarded to the router
    always_comb begin
        ready_en = 1'b0;
        case (state_q)
            HDR, PLD, PAR: ready_en = ~busy;
            DROP:          ready_en = 1'b1;
            default:       ready_en = 1'b0;
        endcase
    end

    assign src_ready = gnt & {N_SRC{ready_en}};
    assign xfer      = cur_valid & ready_en;
    assign trunc_ok  = ~cur_valid & ~busy;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        par_d       = par_q;
        data_d      = data_in;
        pkt_valid_d = pkt_valid;
        err_addr_d  = 1'b0;
        err_trunc_d = 1'b0;
        err_par_d   = 1'b0;
        trunc       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d    = pick_onehot;
                    rr_ptr_d = pick_idx;
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (xfer) begin
                    cnt_d = hdr_len(cur_byte);
                    if (hdr_addr(cur_byte) == ADDR_INVALID) begin
                        err_addr_d = 1'b1;
                        state_d    = DROP;
                    end else begin
                        data_d      = cur_byte;
                        pkt_valid_d = 1'b1;
                        par_d       = cur_byte;
                        state_d     = (hdr_len(cur_byte) == '0) ? PAR : PLD;
                    end
                end
            end
            PLD: begin
                if (xfer) begin
                    data_d      = cur_byte;
                    pkt_valid_d = 1'b1;
                    par_d       = par_q ^ cur_byte;
                    cnt_d       = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = PAR;
                    end
                end else if (trunc_ok) begin
                    trunc = 1'b1;
                end
            end
            PAR: begin
                if (xfer) begin
                    data_d      = cur_byte;
                    pkt_valid_d = 1'b0;
                    err_par_d   = (cur_byte != par_q);
                    gnt_d       = '0;
                    state_d     = GAP;
                end else if (trunc_ok) begin
                    trunc = 1'b1;
                end
            end
            DROP: begin
                if (xfer) begin
                    if (cnt_q == '0) begin
                        gnt_d   = '0;
                        state_d = GAP;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            GAP: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Inverted parity makes the router flag the cut-short packet itself
        if (trunc) begin
            data_d      = par_q ^ '1;
            pkt_valid_d = 1'b0;
            err_trunc_d = 1'b1;
            gnt_d       = '0;
            state_d     = GAP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            gnt       <= '0;
            rr_ptr_q  <= IDX_W'(N_SRC - 1);
            cnt_q     <= '0;
            par_q     <= '0;
            data_in   <= '0;
            pkt_valid <= 1'b0;
            err_addr  <= 1'b0;
            err_trunc <= 1'b0;
            err_par   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt       <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            data_in   <= data_d;
            pkt_valid <= pkt_valid_d;
            err_addr  <= err_addr_d;
            err_trunc <= err_trunc_d;
            err_par   <= err_par_d;
        end
    end

endmodule

// File: tb/tb_router_ingress_arb.sv
// Bench for router_ingress_arb: directed scenarios plus randomized multi-source
// traffic checked against a byte-stream reference model.
module tb_router_ingress_arb;

    localparam int N = 4;
    localparam logic [1:0] K_HDR = 2'd0;
    localparam logic [1:0] K_PLD = 2'd1;
    localparam logic [1:0] K_PAR = 2'd2;

    typedef struct {
        logic [7:0] b;
        logic [1:0] kind;
        bit         drop;
        bit         bad;
    } ent_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   src_valid;
    logic [N*8-1:0] src_data;
    logic [N-1:0]   src_ready;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [7:0]     data_in;
    logic           pkt_valid, err_addr, err_trunc, err_par;
    logic [7:0]     sd [N];

    for (genvar i = 0; i < N; i++) begin : g_sd
        assign src_data[i*8 +: 8] = sd[i];
    end

    router_ingress_arb #(.N_SRC(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .gnt       (gnt),
        .busy      (busy),
        .data_in   (data_in),
        .pkt_valid (pkt_valid),
        .err_addr  (err_addr),
        .err_trunc (err_trunc),
        .err_par   (err_par)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    ent_t         srcq [N][$];
    logic [8:0]   obs [$];
    logic [N-1:0] glog [$];
    logic [8:0]   w [6];
    logic [7:0]   exp_d;
    logic         exp_pv;
    int           last_pick;
    int           ea_cnt, et_cnt, ep_cnt;
    bit           bubble_en;
    logic [N-1:0] last_ready;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push_ent(input int s, input logic [7:0] b, input logic [1:0] k,
                            input bit drop, input bit bad);
        ent_t e;
        e.b = b; e.kind = k; e.drop = drop; e.bad = bad;
        srcq[s].push_back(e);
    endtask

    // Packet with up to 4 payload bytes taken LSB-first from pl
    task automatic add_pkt(input int s, input logic [7:0] h, input logic [31:0] pl,
                           input logic [7:0] parity);
        logic [7:0] x, b;
        bit drop;
        drop = (h[1:0] == 2'b11);
        x = h;
        push_ent(s, h, K_HDR, drop, 1'b0);
        for (int i = 0; i < int'(h[7:2]) && i < 4; i++) begin
            b = pl[8*i +: 8];
            x = x ^ b;
            push_ent(s, b, K_PLD, drop, 1'b0);
        end
        push_ent(s, parity, K_PAR, drop, parity != x);
    endtask

    task automatic add_rand_pkt(input int s);
        logic [7:0] h, x, b;
        int len;
        bit drop;
        len = $urandom_range(0, 5);
        h = {6'(len), 2'($urandom_range(0, 3))};
        drop = (h[1:0] == 2'b11);
        x = h;
        push_ent(s, h, K_HDR, drop, 1'b0);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            push_ent(s, b, K_PLD, drop, 1'b0);
        end
        if ($urandom_range(0, 3) == 0) b = x ^ 8'($urandom_range(1, 255));
        else b = x;
        push_ent(s, b, K_PAR, drop, b != x);
    endtask

    // One clock: drive sources from their queues, then check the router view
    task automatic tick(input bit trunc_exp = 1'b0, input logic [7:0] trunc_val = 8'h00);
        logic [N-1:0] v, r, g_pre, xfer, want;
        ent_t e;
        bit have;
        logic exp_ea, exp_ep;
        int p;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 &&
                !(bubble_en && (srcq[i][0].kind == K_HDR || srcq[i][0].drop) &&
                  $urandom_range(0, 3) == 0)) begin
                src_valid[i] = 1'b1;
                sd[i] = srcq[i][0].b;
            end else begin
                src_valid[i] = 1'b0;
                sd[i] = 8'($urandom);
            end
        end
        #2;
        v = src_valid; r = src_ready; g_pre = gnt; last_ready = r;
        chk("ready_owner", 32'(r & ~g_pre), 0);
        chk("ready_onehot", 32'($onehot0(r)), 1);
        @(posedge clk);
        #1;
        xfer = v & r;
        have = 1'b0; exp_ea = 1'b0; exp_ep = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) begin
                e = srcq[i].pop_front();
                have = 1'b1;
            end
        end
        if (have) begin
            if (e.drop) begin
                exp_ea = (e.kind == K_HDR);
            end else begin
                exp_d  = e.b;
                exp_pv = (e.kind != K_PAR);
                exp_ep = (e.kind == K_PAR) && e.bad;
                obs.push_back({pkt_valid, data_in});
            end
        end
        if (trunc_exp) begin
            exp_d  = trunc_val;
            exp_pv = 1'b0;
            obs.push_back({pkt_valid, data_in});
        end
        chk("data_in", 32'(data_in), 32'(exp_d));
        chk("pkt_valid", 32'(pkt_valid), 32'(exp_pv));
        chk("err_addr", 32'(err_addr), 32'(exp_ea));
        chk("err_par", 32'(err_par), 32'(exp_ep));
        chk("err_trunc", 32'(err_trunc), 32'(trunc_exp));
        if (err_addr) ea_cnt++;
        if (err_trunc) et_cnt++;
        if (err_par) ep_cnt++;
        if (g_pre == '0 && gnt != '0) begin
            want = '0;
            p = last_pick;
            for (int k = 1; k <= N; k++) begin
                if (want == '0 && v[(last_pick + k) % N]) begin
                    p = (last_pick + k) % N;
                    want[p] = 1'b1;
                end
            end
            chk("grant_rr", 32'(gnt), 32'(want));
            last_pick = p;
            glog.push_back(gnt);
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((pending() || gnt != '0) && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain_bound", 32'(n < max_cyc), 1);
        tick();
        tick();
    endtask

    task automatic tick_until_obs(input int cnt, input int max_cyc);
        int n;
        n = 0;
        while (obs.size() < cnt && n < max_cyc) begin
            tick();
            n++;
        end
        chk("obs_bound", 32'(n < max_cyc), 1);
    endtask

    task automatic tick_until_glog(input int cnt, input int max_cyc);
        int n;
        n = 0;
        while (glog.size() < cnt && n < max_cyc) begin
            tick();
            n++;
        end
        chk("glog_bound", 32'(n < max_cyc), 1);
    endtask

    task automatic cmp_obs(input string tag, input int n);
        chk({tag, "_len"}, 32'(obs.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < obs.size()) chk($sformatf("%s_%0d", tag, i), 32'(obs[i]), 32'(w[i]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        busy  = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_data", 32'(data_in), 0);
        chk("rst_pv", 32'(pkt_valid), 0);
        chk("rst_err", 32'({err_addr, err_trunc, err_par}), 0);
        chk("rst_ready", 32'(src_ready), 0);
        for (int i = 0; i < N; i++) srcq[i].delete();
        obs.delete();
        glog.delete();
        src_valid = '0;
        exp_d = 8'h00; exp_pv = 1'b0; last_pick = N - 1;
        ea_cnt = 0; et_cnt = 0; ep_cnt = 0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; busy = 1'b0; src_valid = '0; bubble_en = 1'b0;
        for (int i = 0; i < N; i++) sd[i] = 8'h00;
        #3;
        do_reset();

        // Basic packet from source 0
        add_pkt(0, 8'h0D, 32'h0033_2211, 8'h0D);
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        drain(50);
        w = '{9'h10D, 9'h111, 9'h122, 9'h133, 9'h00D, 9'h000};
        cmp_obs("t1_stream", 5);
        chk("t1_errs", 32'(ea_cnt + et_cnt + ep_cnt), 0);
        chk("t1_gnt_idle", 32'(gnt), 0);

        // Busy stall after payload byte 11
        obs.delete();
        add_pkt(0, 8'h0D, 32'h0033_2211, 8'h0D);
        tick_until_obs(2, 20);
        busy = 1'b1;
        repeat (3) begin
            tick();
            chk("t2_ready", 32'(last_ready), 0);
            chk("t2_hold", 32'(data_in), 32'h11);
        end
        busy = 1'b0;
        drain(50);
        cmp_obs("t2_stream", 5);

        // Round-robin order from reset
        do_reset();
        add_pkt(1, 8'h04, 32'h5A, 8'h5E);
        add_pkt(2, 8'h06, 32'hA5, 8'hA3);
        tick_until_glog(2, 40);
        add_pkt(1, 8'h04, 32'h5A, 8'h5E);
        drain(100);
        chk("t3_glog_len", 32'(glog.size()), 3);
        if (glog.size() == 3) begin
            chk("t3_gnt0", 32'(glog[0]), 32'h2);
            chk("t3_gnt1", 32'(glog[1]), 32'h4);
            chk("t3_gnt2", 32'(glog[2]), 32'h2);
        end

        // Invalid address is dropped
        obs.delete();
        ea_cnt = 0;
        add_pkt(0, 8'h0B, 32'h0000_BBAA, 8'hCC);
        drain(50);
        chk("t4_err_addr", 32'(ea_cnt), 1);
        chk("t4_no_fwd", 32'(obs.size()), 0);
        chk("t4_data_held", 32'(data_in), 32'h5E);
        chk("t4_pv_low", 32'(pkt_valid), 0);
        chk("t4_consumed", 32'(srcq[0].size()), 0);

        // Truncation mid-payload
        obs.delete();
        et_cnt = 0;
        push_ent(0, 8'h0D, K_HDR, 1'b0, 1'b0);
        push_ent(0, 8'h11, K_PLD, 1'b0, 1'b0);
        tick_until_obs(2, 20);
        tick(1'b1, 8'hE3);
        chk("t5_gnt_rel", 32'(gnt), 0);
        chk("t5_err_trunc", 32'(et_cnt), 1);
        drain(10);

        // Zero-length packet with bad parity, then reset mid-payload
        obs.delete();
        ep_cnt = 0;
        add_pkt(0, 8'h02, 32'h0, 8'h00);
        drain(30);
        w = '{9'h102, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
        cmp_obs("t6_stream", 2);
        chk("t6_err_par", 32'(ep_cnt), 1);
        add_pkt(0, 8'h0D, 32'h0033_2211, 8'h0D);
        tick_until_obs(4, 20);
        chk("t6_pre_rst_pv", 32'(pkt_valid), 1);
        do_reset();

        // Randomized traffic from all sources with busy and bubbles
        bubble_en = 1'b1;
        for (int s = 0; s < N; s++) begin
            for (int p = 0; p < 8; p++) add_rand_pkt(s);
        end
        begin
            int n;
            n = 0;
            while ((pending() || gnt != '0) && n < 20000) begin
                busy = ($urandom_range(0, 3) == 0);
                tick();
                n++;
            end
            busy = 1'b0;
            chk("rand_bound", 32'(n < 20000), 1);
        end
        bubble_en = 1'b0;
        tick();
        tick();
        chk("rand_grants", 32'(glog.size()), 32'(N * 8));
        chk("rand_no_trunc", 32'(et_cnt), 0);
        chk("rand_idle", 32'(gnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_ingress_arb.md
# router_ingress_arb

Ingress arbiter and packet framer in front of the 1x3 router input port. It shares the router's single `data_in`/`pkt_valid` input among up to four packet sources, granting round-robin at packet boundaries. It generates router framing from the header length field and honours router `busy` back-pressure. It also drops packets addressed to the invalid port 3, and detects truncated packets and source parity errors.

## Interface
- `N_SRC`, default 4: number of sources, legal range 2..4.
- `clk` input, 1 bit: system clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `src_valid` input, `N_SRC` bits: source i has a byte on `src_data` slice i.
- `src_data` input, `N_SRC*8` bits: flat byte bus; slice i is bits [8i+7:8i].
- `src_ready` output, `N_SRC` bits: byte of source i accepted at this edge when high together with `src_valid[i]`.
- `gnt` output, `N_SRC` bits: one-hot current owner; all zero when idle.
- `busy` input, 1 bit: router busy; the router neither samples `data_in` nor expects it to change.
- `data_in` output, 8 bits: registered router input byte.
- `pkt_valid` output, 1 bit: registered router frame flag; high for header and payload, low for parity.
- `err_addr` output, 1 bit: one-cycle pulse when a header with addr=2'b11 is accepted.
- `err_trunc` output, 1 bit: one-cycle pulse when a packet is truncated.
- `err_par` output, 1 bit: one-cycle pulse when a source parity byte mismatches.

## Operation
- Packet format: header {len[7:2], addr[1:0]}, then len payload bytes, then parity = XOR of header and all payload bytes. len = 0 is legal.
- A transfer occurs when `src_valid[g]` & `src_ready[g]`, where g is the granted source.
- `src_ready[g]` = ~`busy` in HDR, PLD and PAR; it is 1 in DROP; it is 0 otherwise. Non-granted sources always see `src_ready` = 0.
- The output register loads only on a transfer edge, or on a truncation edge, and only if ~`busy`. Otherwise `data_in` and `pkt_valid` hold their values.
- State machine:
  - IDLE: `pkt_valid` = 0. If any `src_valid` is high, pick the first requester after `rr_ptr` (cyclic), register `gnt`, set `rr_ptr` to that index, and go to HDR.
  - HDR, on transfer:
    - addr == 3: pulse `err_addr`, set cnt = len, go to DROP. The output register is untouched.
    - otherwise: load `data_in` = header and `pkt_valid` = 1, set par = header and cnt = len, then go to PLD if len ≠ 0, else PAR.
  - PLD:
    - On transfer: load the byte with `pkt_valid` = 1, set par ^= byte, decrement cnt, and go to PAR when cnt reaches 0.
    - If `src_valid[g]` = 0 and ~`busy`: truncate.
  - PAR:
    - On transfer: load the byte with `pkt_valid` = 0, and pulse `err_par` if byte ≠ par. The byte is forwarded unchanged. Go to GAP.
    - If `src_valid[g]` = 0 and ~`busy`: truncate.
  - Truncate: load `data_in` = par ^ 8'hFF with `pkt_valid` = 0, pulse `err_trunc`, go to GAP. The router then flags a parity error.
  - DROP: consume bytes, waiting through bubbles. At cnt == 0 the transfer consumes the parity byte and the state goes to GAP; otherwise cnt decrements.
  - GAP: `gnt` = 0. Go to IDLE on the next edge.
- cnt is 6 bits and never underflows. par is 8 bits.
- A source that drops `src_valid` in HDR or DROP simply stalls those states; this is not an error.

## Timing
- Reset, asynchronous while `reset` = 0:
  - state = IDLE, `rr_ptr` = `N_SRC`-1 (source 0 has first priority).
  - `gnt`, `data_in`, `pkt_valid`, `err_*`, cnt and par = 0.
  - A reset mid-packet abandons the packet with no error pulse.
- Grant latency: `src_valid` seen high at edge k in IDLE gives `gnt` valid after edge k. The first `src_ready` can be high in the cycle after edge k.
- Byte latency: a byte transferred at edge k appears on `data_in` after edge k. It holds until the next load edge, which the router consumes because `busy` = 0 at that edge.
- Back-to-back packets: minimum of 2 non-transfer cycles between parity and the next header (GAP + IDLE).
- Simultaneous requests resolve by round-robin only; the fairness bound is `N_SRC`-1 packets.
- `err_*` pulses are registered and asserted in the cycle after the causing edge.

## Structure
- Shared package `router_pkg` holds:
  - state enum {IDLE, HDR, PLD, PAR, DROP, GAP};
  - `LEN_W` = 6, `DATA_W` = 8, `ADDR_INVALID` = 2'b11;
  - the header field extract helpers.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are a request vector and a pointer; outputs are the one-hot grant and its index, parameterised by `N_SRC`.

## Test plan
- Source 0 sends 0D,11,22,33,0D: `gnt` = 0001 one cycle after `src_valid`. Router sees 0D/1, 11/1, 22/1, 33/1, 0D/0 (byte/`pkt_valid`). No errors; `gnt` returns to 0 after GAP.
- Same packet with `busy` forced high for 3 cycles after byte 11: `src_ready` = 0 and `data_in` held at 11 for 3 cycles, then the sequence resumes with no loss or duplication.
- Sources 1 and 2 request together from reset: source 1 is served first, then source 2. Source 1 re-requesting during source 2's packet is served third, so `gnt` order is 0010, 0100, 0010.
- Header 0B (len 2, addr 3) followed by 3 bytes: `err_addr` pulses once, `pkt_valid` stays 0, `data_in` is unchanged, 3 bytes are consumed, and DROP exits to GAP.
- Header 0D, payload 11, then `src_valid` drops: `data_in` = E3 with `pkt_valid` = 0, `err_trunc` pulses once, and `gnt` is released.
- Header 02 (len 0) then parity 00:
  - router sees 02/1 then 00/0;
  - `err_par` pulses once and 00 is forwarded unchanged, since 00 ≠ 02;
  - asserting `reset` low mid-PLD on a following packet clears all outputs immediately.
